// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for program_loader and its word packer.
//   loader_state_t : loader FSM state encoding
//   ADDR_W_DEF     : default RAM word-address width (PC width)
//   DATA_W_DEF     : default RAM word width (the packer assumes 32)
//   BYTES_PER_WORD : stream bytes packed into one RAM word
package loader_pkg;

  localparam int unsigned ADDR_W_DEF     = 11;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// word_packer: packs a little-endian byte stream into 32-bit words.
// The first accepted byte of a word lands in bits 7:0.
// Optional macro LOADER_CHECKSUM_EN adds a running 8-bit sum of all taken bytes.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_clear       : restart packing (new load)
//   i_take        : a data byte is accepted this cycle
//   i_byte        : the byte being accepted
//   o_word_next   : current word with i_byte placed in its lane (valid with o_word_full)
//   o_word_full   : the byte taken this cycle completes a word
//   o_csum        : running byte sum (LOADER_CHECKSUM_EN only)
module word_packer
  import loader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_take,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word_next,
  output logic              o_word_full
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        o_csum
`endif
);

  logic [DATA_W-1:0] r_word;
  logic [1:0]        r_byte_idx;

  // The completed word is offered combinationally so the top can register
  // it on the same edge that accepts the 4th byte.
  always_comb begin
    o_word_next = r_word;
    o_word_next[{r_byte_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_word_full = i_take && (r_byte_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_idx <= '0;
    end else if (i_clear) begin
      r_word     <= '0;
      r_byte_idx <= '0;
    end else if (i_take) begin
      r_word     <= o_word_next;
      r_byte_idx <= r_byte_idx + 2'd1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (i_clear) begin
      r_csum <= '0;
    end else if (i_take) begin
      r_csum <= r_csum + i_byte;
    end
  end

  assign o_csum = r_csum;
`endif

endmodule

// File: rtl/program_loader.sv
// program_loader: loads a little-endian byte stream into the instruction RAM
// through port B while holding the CPU in reset, then releases the CPU with
// start_pc = load base address.
// Optional macro LOADER_CHECKSUM_EN: after the last word one extra byte is
// accepted; the 8-bit sum of all data bytes plus that byte must be 0x00.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   load_start              : single-cycle load request (accepted only when idle)
//   load_base, load_len     : first word address / word count (0..2^ADDR_W)
//   byte_valid, byte_data   : byte stream input
//   byte_ready              : loader accepts a byte this cycle
//   ram_w_en, ram_addr, ram_in : RAM port-B write
//   cpu_rst_n, start_pc     : CPU reset (active low) and release PC
//   busy, done, err         : status (done/err sticky until next accepted load)
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // 2^ADDR_W, two bits wider than an address so base + len cannot overflow.
  localparam logic [ADDR_W+1:0] ADDR_SPACE = {2'b01, {ADDR_W{1'b0}}};

  loader_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_word_idx;

  logic              r_byte_ready;
  logic              r_ram_w_en;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_in;
  logic              r_cpu_rst_n;
  logic [ADDR_W-1:0] r_start_pc;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W+1:0] w_load_end;
  logic              w_in_range;
  logic              w_accept;
  logic              w_reject;
  logic              w_hs;
  logic              w_take;
  logic              w_word_full;
  logic              w_last_word;
  logic              w_csum_fail;
  logic [DATA_W-1:0] w_word_next;

  assign w_load_end  = {2'b00, load_base} + {1'b0, load_len};
  assign w_in_range  = (w_load_end <= ADDR_SPACE);
  assign w_accept    = load_start && (r_state == IDLE) && w_in_range;
  assign w_reject    = load_start && (r_state == IDLE) && !w_in_range;
  assign w_hs        = byte_valid && r_byte_ready;
  assign w_take      = w_hs && (r_state == RECV);
  assign w_last_word = ((r_word_idx + 1'b1) == r_len);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] w_csum;
`endif

  word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_accept),
    .i_take      (w_take),
    .i_byte      (byte_data),
    .o_word_next (w_word_next),
    .o_word_full (w_word_full)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_csum      (w_csum)
`endif
  );

  always_comb begin
    w_state_nxt = r_state;
    w_csum_fail = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (load_len == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (w_word_full) begin
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_nxt = CHECK;
`else
          w_state_nxt = DONE;
`endif
        end else begin
          w_state_nxt = RECV;
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_hs) begin
          if (8'(w_csum + byte_data) == 8'h00) begin
            w_state_nxt = DONE;
          end else begin
            w_csum_fail = 1'b1;
            w_state_nxt = IDLE;
          end
        end
`else
        w_state_nxt = DONE;
`endif
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid in the
  // same cycle as the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_ready <= 1'b0;
      r_ram_w_en   <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_in     <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_start_pc   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_ready <= (w_state_nxt == RECV) || (w_state_nxt == CHECK);
      r_busy       <= w_state_nxt inside {RECV, WRITE, CHECK};
      r_ram_w_en   <= (w_state_nxt == WRITE);

      if (w_word_full) begin
        r_ram_addr <= r_base + r_word_idx[ADDR_W-1:0];
        r_ram_in   <= w_word_next;
      end

      if (r_state == WRITE) begin
        r_word_idx <= r_word_idx + 1'b1;
      end

      if (w_accept) begin
        r_base      <= load_base;
        r_len       <= load_len;
        r_word_idx  <= '0;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_cpu_rst_n <= 1'b0;
      end

      if (w_reject || w_csum_fail) begin
        r_err <= 1'b1;
      end

      // Placed after the accept clears so a zero-length load, which enters
      // DONE straight from IDLE, still ends with done/cpu_rst_n set. Its base
      // has not been latched yet, hence the direct use of load_base.
      if (w_state_nxt == DONE) begin
        r_done      <= 1'b1;
        r_cpu_rst_n <= 1'b1;
        r_start_pc  <= (r_state == IDLE) ? load_base : r_base;
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign ram_w_en   = r_ram_w_en;
  assign ram_addr   = r_ram_addr;
  assign ram_in     = r_ram_in;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign start_pc   = r_start_pc;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
